wb_display_sequencer: RTL and testbench

- Sits downstream of the dual-ALU writeback and upstream of the alu_7seg_mux display driver.
- Captures ALU results from datapaths 1 and 2 into a small circular history buffer, sampled on the slow display clock.
- Presents one buffered result per tick to the 7-segment driver, so both datapaths' results are viewable at human speed instead of only datapath 1's low byte.
- Supports pause via the board pushbutton and flags lost results.

---
 rtl/wb_display_sequencer.sv | 164 ++++++++++++++++
 tb/tb_wb_display_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_display_sequencer.sv
// wb_display_sequencer
// Buffers ALU writeback results from both datapaths in a small circular
// history and shows one of them per display-clock tick on the 7-segment
// driver. A synchronized pushbutton pauses the display; results that find
// no free slot are dropped and flagged by a sticky overflow bit.
module wb_display_sequencer #(
    parameter int DEPTH      = 8,
    parameter int DWIDTH     = 32,
    parameter int DISP_WIDTH = 8
) (
    input  logic                     hz1_clk,
    input  logic                     n_rst,
    input  logic                     wr_en1,
    input  logic [DWIDTH-1:0]        wr_data1,
    input  logic                     wr_en2,
    input  logic [DWIDTH-1:0]        wr_data2,
    input  logic                     hold_btn,
    output logic [DISP_WIDTH-1:0]    disp_value,
    output logic [1:0]               disp_src,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     paused
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Buffer entry: {source tag (1 = datapath 2), result}
    logic [DWIDTH:0] mem [DEPTH];

    logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_p1;
    logic [CW-1:0]   count_nxt, free_slots;
    logic            hold_q1, hold_s;
    logic            pop;
    logic            we_a, we_b;
    logic [DWIDTH:0] entry_a;
    logic [1:0]      push_cnt;
    logic            drop;
    logic [DWIDTH:0] rd_entry;

    assign wr_ptr_p1 = wr_ptr + AW'(1);
    assign rd_entry  = mem[rd_ptr];

    // Two-flop synchronizer for the raw pushbutton
    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_q1 <= 1'b0;
            hold_s  <= 1'b0;
        end else begin
            hold_q1 <= hold_btn;
            hold_s  <= hold_q1;
        end
    end

    // Push arbitration: decide which results are accepted this edge.
    // A pop in the same edge frees its slot for an incoming result.
    always_comb begin
        pop        = (state == SHOW) && (count != '0);
        free_slots = CW'(DEPTH) - count + CW'(pop);
        we_a       = 1'b0;
        we_b       = 1'b0;
        entry_a    = {1'b0, wr_data1};
        push_cnt   = 2'd0;
        drop       = 1'b0;
        if (wr_en1 && wr_en2) begin
            if (free_slots >= CW'(2)) begin
                we_a     = 1'b1;
                we_b     = 1'b1;
                push_cnt = 2'd2;
            end else if (free_slots == CW'(1)) begin
                we_a     = 1'b1;
                push_cnt = 2'd1;
                drop     = 1'b1;
            end else begin
                drop     = 1'b1;
            end
        end else if (wr_en1 || wr_en2) begin
            entry_a = wr_en2 ? {1'b1, wr_data2} : {1'b0, wr_data1};
            if (free_slots != '0) begin
                we_a     = 1'b1;
                push_cnt = 2'd1;
            end else begin
                drop     = 1'b1;
            end
        end
        count_nxt = count + CW'(push_cnt) - CW'(pop);
    end

    // Next-state logic; the button always wins over buffer-driven moves
    always_comb begin
        state_nxt = state;
        if (hold_s) begin
            state_nxt = PAUSE;
        end else begin
            case (state)
                IDLE:    state_nxt = (count_nxt != '0) ? SHOW : IDLE;
                SHOW:    state_nxt = (count_nxt == '0) ? IDLE : SHOW;
                PAUSE:   state_nxt = (count_nxt != '0) ? SHOW : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer storage; contents need no reset
    always_ff @(posedge hz1_clk) begin
        if (we_a) begin
            mem[wr_ptr] <= entry_a;
        end
        if (we_b) begin
            mem[wr_ptr_p1] <= {1'b1, wr_data2};
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            paused   <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push_cnt);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            overflow <= overflow | drop;
            paused   <= (state_nxt == PAUSE);
        end
    end

    // Display register: updated only on a pop, otherwise frozen
    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            disp_value <= '0;
            disp_src   <= 2'd0;
        end else if (pop) begin
            disp_value <= rd_entry[DISP_WIDTH-1:0];
            disp_src   <= rd_entry[DWIDTH] ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: tb/tb_wb_display_sequencer.sv
// Self-checking bench for wb_display_sequencer: a queue-based model of the
// history buffer predicts every output after each display-clock edge.
module tb_wb_display_sequencer;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int DISPW = 8;
    localparam int CW    = 4;

    logic             hz1_clk;
    logic             n_rst;
    logic             wr_en1;
    logic [DW-1:0]    wr_data1;
    logic             wr_en2;
    logic [DW-1:0]    wr_data2;
    logic             hold_btn;
    logic [DISPW-1:0] disp_value;
    logic [1:0]       disp_src;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;
    logic             paused;

    wb_display_sequencer #(
        .DEPTH(DEPTH),
        .DWIDTH(DW),
        .DISP_WIDTH(DISPW)
    ) dut (
        .hz1_clk(hz1_clk),
        .n_rst(n_rst),
        .wr_en1(wr_en1),
        .wr_data1(wr_data1),
        .wr_en2(wr_en2),
        .wr_data2(wr_data2),
        .hold_btn(hold_btn),
        .disp_value(disp_value),
        .disp_src(disp_src),
        .count(count),
        .full(full),
        .overflow(overflow),
        .paused(paused)
    );

    initial hz1_clk = 1'b0;
    always #5 hz1_clk = ~hz1_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {tag, data}; mode 0 idle, 1 showing, 2 paused
    logic [DW:0]      mq[$];
    int               m_mode;
    logic             m_h1, m_h2;
    logic [DISPW-1:0] m_disp;
    logic [1:0]       m_src;
    logic             m_ovf;

    function automatic void model_reset();
        mq.delete();
        m_mode = 0;
        m_h1   = 1'b0;
        m_h2   = 1'b0;
        m_disp = '0;
        m_src  = 2'd0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_push(input logic tag, input logic [DW-1:0] d);
        mq.push_back({tag, d});
    endfunction

    // One display-clock edge of the specified behaviour
    function automatic void model_edge(input logic e1, input logic [DW-1:0] d1,
                                       input logic e2, input logic [DW-1:0] d2,
                                       input logic h);
        logic [DW:0] e;
        int free;
        if (m_mode == 1 && mq.size() != 0) begin
            e = mq.pop_front();
            m_disp = e[DISPW-1:0];
            m_src  = e[DW] ? 2'd2 : 2'd1;
        end
        free = DEPTH - mq.size();
        if (e1 && e2) begin
            if (free >= 2) begin
                model_push(1'b0, d1);
                model_push(1'b1, d2);
            end else if (free == 1) begin
                model_push(1'b0, d1);
                m_ovf = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (e1 || e2) begin
            if (free >= 1) model_push(e2, e2 ? d2 : d1);
            else m_ovf = 1'b1;
        end
        if (m_h2) m_mode = 2;
        else m_mode = (mq.size() != 0) ? 1 : 0;
        m_h2 = m_h1;
        m_h1 = h;
    endfunction

    function automatic logic [16:0] pack_dut();
        return {disp_value, disp_src, count, full, overflow, paused};
    endfunction

    function automatic logic [16:0] pack_model();
        logic [CW-1:0] c;
        c = CW'(mq.size());
        return {m_disp, m_src, c, (mq.size() == DEPTH), m_ovf, (m_mode == 2)};
    endfunction

    task automatic step(input logic e1, input logic [DW-1:0] d1,
                        input logic e2, input logic [DW-1:0] d2, input logic h);
        wr_en1   = e1;
        wr_data1 = d1;
        wr_en2   = e2;
        wr_data2 = d2;
        hold_btn = h;
        @(posedge hz1_clk);
        model_edge(e1, d1, e2, d2, h);
        #1;
    endtask

    task automatic do_reset();
        @(negedge hz1_clk);
        n_rst    = 1'b0;
        wr_en1   = 1'b0;
        wr_en2   = 1'b0;
        hold_btn = 1'b0;
        model_reset();
        @(negedge hz1_clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (pack_dut() !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", pack_dut(), 17'h0);
        end
    endtask

    task automatic test_single();
        logic [16:0] g, x;
        do_reset();
        step(1'b1, 32'h0000_0A5C, 1'b0, '0, 1'b0);
        checks++;
        if (count !== 4'd1 || disp_value !== 8'h00) begin
            errors++;
            $display("FAIL single_edge1: got count=%0d disp=%h expected count=1 disp=00", count, disp_value);
        end
        step(1'b0, '0, 1'b0, '0, 1'b0);
        checks++;
        if (disp_value !== 8'h5C || disp_src !== 2'd1 || count !== 4'd0) begin
            errors++;
            $display("FAIL single_edge2: got disp=%h src=%0d count=%0d expected 5c/1/0", disp_value, disp_src, count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0);
            g = pack_dut();
            x = pack_model();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL single_idle step %0d: got %h expected %h", i, g, x);
            end
        end
    endtask

    task automatic test_dual_stream();
        logic [16:0] g, x;
        logic [DW-1:0] a, b;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            a[7:0] = 8'h11;
            b[7:0] = 8'h22;
            step(1'b1, a, 1'b1, b, 1'b0);
            g = pack_dut();
            x = pack_model();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL dual_stream step %0d: got %h expected %h", i, g, x);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0);
            g = pack_dut();
            x = pack_model();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL dual_drain step %0d: got %h expected %h", i, g, x);
            end
        end
    endtask

    task automatic test_pause_fill();
        logic [16:0] g, x;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, $urandom, 1'b0, '0, 1'b1);
            g = pack_dut();
            x = pack_model();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL pause_fill step %0d: got %h expected %h", i, g, x);
            end
        end
        checks++;
        if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || paused !== 1'b1 || disp_value !== 8'h00) begin
            errors++;
            $display("FAIL pause_full_flags: got c=%0d f=%b o=%b p=%b d=%h expected 8/1/1/1/00",
                     count, full, overflow, paused, disp_value);
        end
    endtask

    task automatic test_partial_and_release();
        logic [16:0] g, x;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, $urandom, 1'b1);
        checks++;
        if (count !== 4'd7 || paused !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL partial_prefill: got c=%0d p=%b o=%b expected 7/1/0", count, paused, overflow);
        end
        step(1'b1, 32'h0000_0033, 1'b1, 32'h0000_0044, 1'b1);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL partial_33_44: got c=%0d o=%b f=%b expected 8/1/1", count, overflow, full);
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0);
            g = pack_dut();
            x = pack_model();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL release step %0d: got %h expected %h", i, g, x);
            end
        end
        checks++;
        if (disp_value !== 8'h33 || disp_src !== 2'd1 || count !== 4'd0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL release_last: got d=%h s=%0d c=%0d p=%b expected 33/1/0/0",
                     disp_value, disp_src, count, paused);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] g, x;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, $urandom, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        checks++;
        if (count !== 4'd4 || disp_src === 2'd0) begin
            errors++;
            $display("FAIL mid_prefill: got c=%0d s=%0d expected c=4 s!=0", count, disp_src);
        end
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pack_dut() !== 17'h0) begin
            errors++;
            $display("FAIL mid_async_reset: got %h expected %h", pack_dut(), 17'h0);
        end
        @(negedge hz1_clk);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0);
            checks++;
            if (pack_dut() !== 17'h0) begin
                errors++;
                $display("FAIL mid_no_pop step %0d: got %h expected %h", i, pack_dut(), 17'h0);
            end
        end
        step(1'b0, '0, 1'b1, 32'hABCD_0077, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        g = pack_dut();
        x = pack_model();
        checks++;
        if (g !== x || disp_value !== 8'h77 || disp_src !== 2'd2) begin
            errors++;
            $display("FAIL mid_after_push: got %h expected %h", g, x);
        end
    endtask

    task automatic test_random();
        logic [16:0] g, x;
        logic h;
        do_reset();
        h = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) h = ~h;
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, h);
            g = pack_dut();
            x = pack_model();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL random step %0d: got %h expected %h", i, g, x);
            end
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        wr_en1   = 1'b0;
        wr_en2   = 1'b0;
        wr_data1 = '0;
        wr_data2 = '0;
        hold_btn = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_dual_stream();
        test_pause_fill();
        test_partial_and_release();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
